// File: rtl/pmp_tor_scan_ctrl.sv
// Sequential TOR-only PMP checker: one shared comparator scans entries 0..N-1, first match wins.
// Latency k+1 cycles after accept (N on miss); response held in RESP until rsp_ready, no request accepted meanwhile.
module pmp_tor_scan_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic [1:0]                req_size,
  input  logic [1:0]                req_type,
  input  logic                      req_priv_m,
  input  logic [32*NUM_ENTRIES-1:0] pmpaddr,
  input  logic [8*NUM_ENTRIES-1:0]  pmpcfg,
  output logic                      busy,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_allow,
  output logic                      rsp_match,
  output logic [IDX_W-1:0]          rsp_idx
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

  state_t           state;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic [1:0]       type_q;
  logic             priv_m_q;
  logic [IDX_W-1:0] scan_idx;

  logic [IDX_W-1:0] prev_idx;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [1:0]       cfg_a;
  logic [2:0]       cfg_rwx;
  logic             cfg_l;
  logic             perm;
  logic             tor_hit;
  logic             last_entry;
  logic             allow_hit;
  logic             allow_miss;

  // Shared datapath: entry scan_idx against the previous entry's address as its base.
  always_comb begin
    prev_idx   = scan_idx - IDX_W'(1);
    hi         = pmpaddr[32*int'(scan_idx) +: 32];
    lo         = (scan_idx == '0) ? 32'h0 : pmpaddr[32*int'(prev_idx) +: 32];
    cfg_rwx    = pmpcfg[8*int'(scan_idx) +: 3];
    cfg_a      = pmpcfg[8*int'(scan_idx)+3 +: 2];
    cfg_l      = pmpcfg[8*int'(scan_idx)+7];
    tor_hit    = (cfg_a == 2'b01) && (addr_q >= lo) &&
                 (({1'b0, addr_q} + {31'b0, size_q}) < {1'b0, hi});
    last_entry = (scan_idx == IDX_W'(NUM_ENTRIES-1));
    case (type_q)
      2'b00:   perm = cfg_rwx[0];
      2'b01:   perm = cfg_rwx[1];
      2'b10:   perm = cfg_rwx[2];
      default: perm = 1'b0;
    endcase
    allow_hit  = (type_q != 2'b11) && ((priv_m_q && !cfg_l) || perm);
    allow_miss = (type_q != 2'b11) && priv_m_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      type_q    <= '0;
      priv_m_q  <= 1'b0;
      scan_idx  <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_allow <= 1'b0;
      rsp_match <= 1'b0;
      rsp_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            size_q    <= req_size;
            type_q    <= req_type;
            priv_m_q  <= req_priv_m;
            scan_idx  <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (tor_hit) begin
            rsp_match <= 1'b1;
            rsp_idx   <= scan_idx;
            rsp_allow <= allow_hit;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (last_entry) begin
            rsp_match <= 1'b0;
            rsp_idx   <= '0;
            rsp_allow <= allow_miss;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            scan_idx  <= scan_idx + IDX_W'(1);
          end
        end
        S_RESP: begin
          // req_ready only rises here, so a request cannot be taken in the handoff cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pmp_tor_scan_ctrl.md
# pmp_tor_scan_ctrl

Sequential PMP checker controller that shares a single TOR address-match datapath across all PMP entries. It accepts one access request at a time over a valid/ready handshake and scans entries from lowest to highest index, one per cycle. It stops at the first match, applies the matching entry's permissions and privilege rules, and returns an allow/deny response over a second valid/ready handshake. It sits between the load/store/fetch request path and the PMP configuration registers.

## Interface

**Parameters**
- `NUM_ENTRIES`, default 16: number of PMP entries scanned (≥2).
- `IDX_W`, default `$clog2(NUM_ENTRIES)`: width of the entry index.

**Ports**
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: access request valid.
- `req_ready` out 1: controller can accept a request.
- `req_addr` in 32: unsigned byte address of the access.
- `req_size` in 2: access size code; `00` byte, `01` half, `11` word. The code is added to the address as-is.
- `req_type` in 2: `00` read, `01` write, `10` execute, `11` illegal.
- `req_priv_m` in 1: access is from machine mode.
- `pmpaddr` in 32·NUM_ENTRIES: entry i occupies bits [32i+31:32i].
- `pmpcfg` in 8·NUM_ENTRIES: entry i occupies bits [8i+7:8i]. Bit 0 = R, bit 1 = W, bit 2 = X, bits 4:3 = A, bit 7 = L.
- `busy` out 1: a request is held in SCAN or RESP.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_allow` out 1: access permitted.
- `rsp_match` out 1: some entry matched.
- `rsp_idx` out IDX_W: index of the matching entry; 0 if no match.

## Operation

**FSM states:** IDLE, SCAN, RESP.

**IDLE**
- `req_ready` = 1.
- On `req_valid`: latch addr, size, type and priv; clear the scan index; go to SCAN.

**SCAN** (evaluates the entry at scan index k each cycle)
- A = `00` (OFF), `10` (NA4) or `11` (NAPOT): no match in this block.
- A = `01` (TOR): match iff `addr >= lo` AND `{1'b0,addr} + size < {1'b0,pmpaddr[k]}`.
  - `lo` = `pmpaddr[k-1]`, or 0 when k = 0.
  - The comparison is 33-bit, so `addr + size` never wraps.
- On match: latch `rsp_match`=1 and `rsp_idx`=k, compute allow, go to RESP.
- No match and k = NUM_ENTRIES−1: latch `rsp_match`=0 and `rsp_idx`=0, compute allow, go to RESP.
- Otherwise: k+1.

**Allow rules**
- `req_type` = `11`: deny, regardless of the other rules.
- Match found:
  - M-mode with L=0: allow.
  - Otherwise: allow iff the R/W/X bit selected by `req_type` is set.
- No match: allow iff M-mode.

**RESP**
- `rsp_valid` = 1.
- `rsp_*` fields are registered and stay stable until `rsp_ready`.
- On `rsp_ready`: go to IDLE. A new request is not accepted in that same cycle.

**Other rules**
- `pmpaddr`/`pmpcfg` are read live and must remain stable while `busy`=1. The result is undefined if they change mid-scan.
- `busy` = (state ≠ IDLE).

## Timing

- **Reset values:** state IDLE, `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_allow`=0, `rsp_match`=0, `rsp_idx`=0.
- **Accept edge** = the rising edge with `req_valid && req_ready`.
- **Match at entry k:** `rsp_valid` rises k+1 cycles after the accept edge.
- **No match:** `rsp_valid` rises NUM_ENTRIES cycles after the accept edge.
- **Minimum request spacing:** k+3 cycles with `rsp_ready` tied high (accept, k+1 scan cycles, RESP, IDLE).
- **Reset asserted in any state:** outputs return to reset values immediately (asynchronously). The in-flight request is dropped and no response is produced.
- **`rsp_ready` held high before `rsp_valid`:** the response completes in exactly one RESP cycle.

## Test plan

Common configuration for all scenarios: NUM_ENTRIES=4.
- pmpaddr = {0x1000, 0x2000, 0x2000, 0x3000}.
- pmpcfg = {0x09, 0x0B, 0x00, 0x8C}.

1. **Read, entry 0:** U-mode read, addr 0x0800, size 0 → match idx 0, allow=1, `rsp_valid` 1 cycle after accept.
2. **Lower-boundary exact:** U-mode read, 0x1000, size 0 → entry 0 fails (0x1000 < 0x1000 is false) → idx 1, allow=1, latency 2.
3. **Upper-boundary straddle:** U-mode write.
   - 0x1FFC, size 3 → idx 1, allow=1.
   - 0x1FFE, size 3 → no entry matches → match=0, idx 0, allow=0, latency 4.
   - Repeat 0x1FFE in M-mode → allow=1.
4. **Locked entry:** addr 0x2800, entry 3 (L=1, X only).
   - M-mode read → idx 3, allow=0.
   - M-mode execute → allow=1.
   - type `11` → allow=0.
5. **Backpressure:** hold `rsp_ready` low for 3 cycles after `rsp_valid` → fields stable, `req_ready`=0, `busy`=1. Raise `rsp_ready` → IDLE the next cycle, `req_ready`=1.
6. **Reset mid-scan:** assert `rst_n` low during SCAN at k=2 → all outputs reach reset values without waiting for a clock. After release, scenario 1 passes with unchanged latency.
